// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared encodings, FSM states and helpers for the sequential FP multiplier
package fp_mul_pkg;

  // Rounding-mode encoding; codes 5-7 fall through to round-to-nearest-even
  localparam logic [2:0] RND_RNE = 3'd0;
  localparam logic [2:0] RND_RZ  = 3'd1;
  localparam logic [2:0] RND_RUP = 3'd2;
  localparam logic [2:0] RND_RDN = 3'd3;
  localparam logic [2:0] RND_RNA = 3'd4;

  // Status byte bit positions; bits 7:6 always read zero
  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INVALID = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ROUND,
    S_DONE
  } fp_mul_state_t;

  // Canonical quiet NaN: positive, all-ones exponent, fraction MSB only
  function automatic logic [63:0] canon_nan(input int sig_w, input int exp_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << sig_w;
    r = r | (64'd1 << (sig_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - combinational normalize, round, overflow/underflow and status for the multiplier
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic [2*sig_width+1:0]     prod,
  input  logic [exp_width+1:0]       exp_sum,
  input  logic                       sign,
  input  logic [2:0]                 rnd,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                 status
);

  localparam int P  = 2 * sig_width + 2;
  localparam int E2 = exp_width + 2;
  localparam logic [E2-1:0] EMAX = E2'((1 << exp_width) - 1);

  logic [P-1:0]         norm;
  logic [sig_width:0]   mant;
  logic [sig_width+1:0] mant_r;
  logic [sig_width-1:0] frac;
  logic [E2-1:0]        exp_f;
  logic guard, sticky, inexact, round_up, carry, to_inf, overflow, underflow;

  // Normalize the raw product, apply the rounding mode, then classify range
  always_comb begin
    norm     = prod[P-1] ? prod : (prod << 1);
    mant     = norm[P-1:sig_width+1];
    guard    = norm[sig_width];
    sticky   = |norm[sig_width-1:0];
    inexact  = guard | sticky;
    case (rnd)
      RND_RZ:  round_up = 1'b0;
      RND_RUP: round_up = inexact & ~sign;
      RND_RDN: round_up = inexact & sign;
      RND_RNA: round_up = guard;
      default: round_up = guard & (sticky | mant[0]);
    endcase
    mant_r    = {1'b0, mant} + {{(sig_width+1){1'b0}}, round_up};
    carry     = mant_r[sig_width+1];
    // A carry out means the mantissa became exactly 2.0: fraction is zero
    frac      = carry ? mant_r[sig_width:1] : mant_r[sig_width-1:0];
    exp_f     = exp_sum + {{(E2-1){1'b0}}, prod[P-1]} + {{(E2-1){1'b0}}, carry};
    overflow  = ~exp_f[E2-1] && (exp_f >= EMAX);
    underflow = exp_f[E2-1] || (exp_f == '0);
    case (rnd)
      RND_RZ:  to_inf = 1'b0;
      RND_RUP: to_inf = ~sign;
      RND_RDN: to_inf = sign;
      default: to_inf = 1'b1;
    endcase

    z      = {sign, exp_f[exp_width-1:0], frac};
    status = '0;
    status[ST_INEXACT] = inexact;
    if (overflow) begin
      status[ST_HUGE]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
      if (to_inf) begin
        z = {sign, {exp_width{1'b1}}, {sig_width{1'b0}}};
        status[ST_INF] = 1'b1;
      end else begin
        z = {sign, {(exp_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};
      end
    end else if (underflow) begin
      z = {sign, {(sig_width+exp_width){1'b0}}};
      status[ST_ZERO]    = 1'b1;
      status[ST_TINY]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential radix-2 shift-add IEEE-754 multiplier (FP_MUL_EARLY_TERM_EN: early exit from MUL)
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int sig_width = 23,
  parameter int exp_width = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic [2:0]                   rnd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);

  localparam int W  = sig_width + exp_width + 1;
  localparam int M  = sig_width + 1;
  localparam int P  = 2 * M;
  localparam int E2 = exp_width + 2;
  localparam int CW = $clog2(M + 1);
  localparam logic [E2-1:0] BIAS = E2'((1 << (exp_width - 1)) - 1);
  localparam logic [exp_width-1:0] EONES = {exp_width{1'b1}};
  localparam logic [63:0] NAN_WORD = canon_nan(sig_width, exp_width);

  fp_mul_state_t state, state_n;

  logic [P-1:0]   acc;
  logic [M-1:0]   mplier, mcand;
  logic [E2-1:0]  exp_sum;
  logic [CW-1:0]  cnt;
  logic           sign_r;
  logic [2:0]     rnd_r;
  logic [W-1:0]   z_r;
  logic [7:0]     status_r;

  logic [exp_width-1:0] ea, eb;
  logic [sig_width-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special, sign_ab;
  logic [W-1:0] spec_z;
  logic [7:0]   spec_status;

  logic [M:0]   add_term, sum;
  logic [P-1:0] acc_step, prod_aligned;
  logic         mul_last;
  logic [W-1:0] rnd_z;
  logic [7:0]   rnd_status;

  assign ea      = a[W-2:sig_width];
  assign eb      = b[W-2:sig_width];
  assign fa      = a[sig_width-1:0];
  assign fb      = b[sig_width-1:0];
  assign sign_ab = a[W-1] ^ b[W-1];
  // Subnormal operands are flushed to zero by treating exponent 0 as zero
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (ea == EONES) && (fa == '0);
  assign b_inf   = (eb == EONES) && (fb == '0);
  assign a_nan   = (ea == EONES) && (fa != '0);
  assign b_nan   = (eb == EONES) && (fb != '0);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Fast-path result for NaN, infinity and zero operands
  always_comb begin
    spec_z      = {sign_ab, {(W-1){1'b0}}};
    spec_status = '0;
    if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) begin
      spec_z                  = NAN_WORD[W-1:0];
      spec_status[ST_INVALID] = 1'b1;
    end else if (a_inf | b_inf) begin
      spec_z              = {sign_ab, EONES, {sig_width{1'b0}}};
      spec_status[ST_INF] = 1'b1;
    end else begin
      spec_status[ST_ZERO] = 1'b1;
    end
  end

  // One shift-add step: add multiplicand into the upper half, shift right
  assign add_term = mplier[0] ? {1'b0, mcand} : '0;
  assign sum      = {1'b0, acc[P-1:M]} + add_term;
  assign acc_step = {sum, acc[M-1:1]};

`ifdef FP_MUL_EARLY_TERM_EN
  // Once the remaining multiplier bits are zero, the skipped steps are pure shifts
  assign mul_last     = (cnt == CW'(M - 1)) || (mplier[M-1:1] == '0);
  assign prod_aligned = acc >> (CW'(M) - cnt);
`else
  assign mul_last     = (cnt == CW'(M - 1));
  assign prod_aligned = acc;
`endif

  fp_mul_round #(
    .sig_width(sig_width),
    .exp_width(exp_width)
  ) u_round (
    .prod    (prod_aligned),
    .exp_sum (exp_sum),
    .sign    (sign_r),
    .rnd     (rnd_r),
    .z       (rnd_z),
    .status  (rnd_status)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = special ? S_DONE : S_MUL;
      end
      S_MUL:   if (mul_last) state_n = S_ROUND;
      S_ROUND: state_n = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Operand capture, mantissa iteration and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      mplier   <= '0;
      mcand    <= '0;
      exp_sum  <= '0;
      cnt      <= '0;
      sign_r   <= 1'b0;
      rnd_r    <= '0;
      z_r      <= '0;
      status_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign_r <= sign_ab;
            rnd_r  <= rnd;
            if (special) begin
              z_r      <= spec_z;
              status_r <= spec_status;
            end else begin
              acc     <= '0;
              mplier  <= {1'b1, fb};
              mcand   <= {1'b1, fa};
              exp_sum <= {2'b00, ea} + {2'b00, eb} - BIAS;
              cnt     <= '0;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        S_ROUND: begin
          z_r      <= rnd_z;
          status_r <= rnd_status;
        end
        default: ;
      endcase
    end
  end

  assign z      = z_r;
  assign status = status_r;

endmodule
